// File: rtl/uart_fifo_bridge_if.sv
// uart_fifo_bridge_if: CPU register port and UART data port seen by the bridge
interface uart_fifo_bridge_if;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        reg_sta_we;
  logic [31:0] reg_sta_do;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  logic        uart_dat_re;
  logic [31:0] uart_dat_do;
  modport slave (
    input  reg_dat_we, reg_dat_re, reg_dat_di, reg_sta_we, uart_dat_wait, uart_dat_do,
    output reg_dat_do, reg_dat_wait, reg_sta_do, uart_dat_we, uart_dat_di, uart_dat_re
  );
  modport master (
    output reg_dat_we, reg_dat_re, reg_dat_di, reg_sta_we, uart_dat_wait, uart_dat_do,
    input  reg_dat_do, reg_dat_wait, reg_sta_do, uart_dat_we, uart_dat_di, uart_dat_re
  );
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: 8-bit FIFO with wrap-bit pointers; flags and level derive from registered pointers only
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic [7:0] level
);
  logic [DEPTH_LOG2:0] wptr, rptr, diff;
  logic [7:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (DEPTH_LOG2+1)'(1);
      if (pop) rptr <= rptr + (DEPTH_LOG2+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= din;
  assign dout  = mem[rptr[DEPTH_LOG2-1:0]];
  assign empty = wptr == rptr;
  assign full  = wptr == {~rptr[DEPTH_LOG2], rptr[DEPTH_LOG2-1:0]};
  assign diff  = wptr - rptr;
  assign level = 8'(diff);
endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: TX/RX byte FIFOs between CPU register decode and the UART data register
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic               clk,
  input logic               resetn,
  uart_fifo_bridge_if.slave bus
);
  localparam int STA_TX_EMPTY = 16;
  localparam int STA_RX_FULL  = 17;
  localparam int STA_RX_STALL = 18;
  logic active, rx_stall, rx_valid;
  logic tx_push, tx_pop, tx_empty, tx_full;
  logic rx_pop, rx_empty, rx_full;
  logic [7:0] tx_dout, rx_dout, tx_level, rx_level;
  logic unused;
  assign unused   = ^{bus.reg_dat_di[31:8], bus.uart_dat_do[30:8]};
  assign rx_valid = !bus.uart_dat_do[31];
  assign tx_push  = bus.reg_dat_we && !tx_full;
  assign tx_pop   = bus.uart_dat_we && !bus.uart_dat_wait;
  assign rx_pop   = bus.reg_dat_re && !rx_empty;
  assign bus.uart_dat_we  = active && !tx_empty;
  assign bus.uart_dat_re  = active && rx_valid && !rx_full;
  assign bus.uart_dat_di  = {24'b0, tx_empty ? 8'h00 : tx_dout};
  assign bus.reg_dat_wait = bus.reg_dat_we && tx_full;
  assign bus.reg_dat_do   = rx_empty ? 32'hFFFF_FFFF : {24'b0, rx_dout};
  always_comb begin
    bus.reg_sta_do               = {16'b0, rx_level, tx_level};
    bus.reg_sta_do[STA_TX_EMPTY] = tx_empty;
    bus.reg_sta_do[STA_RX_FULL]  = rx_full;
    bus.reg_sta_do[STA_RX_STALL] = rx_stall;
  end
  // a new stall in the same cycle as a status write must not be lost
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      active   <= 1'b0;
      rx_stall <= 1'b0;
    end else begin
      active   <= 1'b1;
      rx_stall <= (rx_valid && rx_full) ? 1'b1 : bus.reg_sta_we ? 1'b0 : rx_stall;
    end
  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(clk), .resetn(resetn), .push(tx_push), .din(bus.reg_dat_di[7:0]), .pop(tx_pop),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .level(tx_level)
  );
  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(clk), .resetn(resetn), .push(bus.uart_dat_re), .din(bus.uart_dat_do[7:0]), .pop(rx_pop),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .level(rx_level)
  );
endmodule
